// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/ERET sequencer.
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_EPC    = 3'd1,
        ST_W_CAUSE  = 3'd2,
        ST_W_STATUS = 3'd3,
        ST_W_BADV   = 3'd4,
        ST_E_STATUS = 3'd5,
        ST_REDIRECT = 3'd6
    } state_t;

    // MIPS ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // CP0 write addresses, encoded {reg[4:0], sel[1:0]}
    localparam logic [6:0] CP0_EPC_ADDR      = 7'h38;
    localparam logic [6:0] CP0_CAUSE_ADDR    = 7'h34;
    localparam logic [6:0] CP0_STATUS_ADDR   = 7'h30;
    localparam logic [6:0] CP0_BADVADDR_ADDR = 7'h20;

    localparam int STATUS_EXL_BIT = 1;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    // Address errors are the only exceptions that also record BadVAddr.
    function automatic logic is_addr_err(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_wdata_gen.sv
// Combinational CP0 write-port mux: maps sequencer state and latched
// exception fields onto the shared CP0 write address/data.
module cp0_wdata_gen
    import exc_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic [2:0]        i_state,
    input  logic [4:0]        i_code,
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_badvaddr,
    input  logic              i_bd,
    input  logic [31:0]       i_status,
    output logic              o_wr_sel,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_data
);

    localparam logic [31:0] EXL_MASK = 32'(1) << STATUS_EXL_BIT;

    // Decode one write per write state; everything reads zero otherwise.
    always_comb begin
        o_wr_sel = 1'b0;
        o_addr   = '0;
        o_data   = '0;
        case (state_t'(i_state))
            ST_W_EPC: begin
                o_wr_sel = 1'b1;
                o_addr   = ADDR_W'(CP0_EPC_ADDR);
                // A delay-slot fault restarts at the branch, one word back.
                o_data   = i_bd ? (i_pc - 32'd4) : i_pc;
            end
            ST_W_CAUSE: begin
                o_wr_sel = 1'b1;
                o_addr   = ADDR_W'(CP0_CAUSE_ADDR);
                o_data   = {i_bd, 24'b0, i_code, 2'b00};
            end
            ST_W_STATUS: begin
                o_wr_sel = 1'b1;
                o_addr   = ADDR_W'(CP0_STATUS_ADDR);
                o_data   = i_status | EXL_MASK;
            end
            ST_W_BADV: begin
                o_wr_sel = 1'b1;
                o_addr   = ADDR_W'(CP0_BADVADDR_ADDR);
                o_data   = i_badvaddr;
            end
            ST_E_STATUS: begin
                o_wr_sel = 1'b1;
                o_addr   = ADDR_W'(CP0_STATUS_ADDR);
                o_data   = i_status & ~EXL_MASK;
            end
            default: begin
                o_wr_sel = 1'b0;
                o_addr   = '0;
                o_data   = '0;
            end
        endcase
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception/ERET sequencer: accepts one committed exception or ERET,
// stalls the pipeline, serialises CP0 writes, then flushes and redirects.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [4:0]        exc_code,
    input  logic [31:0]       exc_pc,
    input  logic [31:0]       exc_badvaddr,
    input  logic              exc_in_delay_slot,
    input  logic              eret_valid,
    input  logic [31:0]       cp0_status,
    input  logic [31:0]       cp0_epc,
    output logic              busy,
    output logic              Exception_Stall,
    output logic              Exception_clean,
    output logic              Exception_Write_addr_sel,
    output logic              Exception_Write_data_sel,
    output logic [ADDR_W-1:0] Exception_RF_addr,
    output logic [31:0]       Exceptiondata,
    output logic              pc_redirect_valid,
    output logic [31:0]       pc_redirect_target
);

    state_t      r_state;
    logic [4:0]  r_code;
    logic [31:0] r_pc;
    logic [31:0] r_badvaddr;
    logic        r_bd;
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic        r_eret;

    state_t      w_next;
    logic        w_accept_exc;
    logic        w_accept_eret;
    logic        w_wr_sel;
    logic        w_redirect;

    // State register and request field capture; reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_code     <= '0;
            r_pc       <= '0;
            r_badvaddr <= '0;
            r_bd       <= 1'b0;
            r_status   <= '0;
            r_epc      <= '0;
            r_eret     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept_exc) begin
                r_code     <= exc_code;
                r_pc       <= exc_pc;
                r_badvaddr <= exc_badvaddr;
                r_bd       <= exc_in_delay_slot;
                r_status   <= cp0_status;
                r_eret     <= 1'b0;
            end else if (w_accept_eret) begin
                r_status <= cp0_status;
                r_epc    <= cp0_epc;
                r_eret   <= 1'b1;
            end
        end
    end

    // Next-state decode; requests are only looked at in IDLE, exception first.
    always_comb begin
        w_next        = r_state;
        w_accept_exc  = 1'b0;
        w_accept_eret = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (exc_valid) begin
                    w_accept_exc = 1'b1;
                    // Nested exception keeps the original EPC.
                    w_next = cp0_status[STATUS_EXL_BIT] ? ST_W_CAUSE : ST_W_EPC;
                end else if (eret_valid) begin
                    w_accept_eret = 1'b1;
                    w_next        = ST_E_STATUS;
                end
            end
            ST_W_EPC:    w_next = ST_W_CAUSE;
            ST_W_CAUSE:  w_next = ST_W_STATUS;
            ST_W_STATUS: w_next = is_addr_err(r_code) ? ST_W_BADV : ST_REDIRECT;
            ST_W_BADV:   w_next = ST_REDIRECT;
            ST_E_STATUS: w_next = ST_REDIRECT;
            ST_REDIRECT: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    cp0_wdata_gen #(
        .ADDR_W (ADDR_W)
    ) u_wdata_gen (
        .i_state    (r_state),
        .i_code     (r_code),
        .i_pc       (r_pc),
        .i_badvaddr (r_badvaddr),
        .i_bd       (r_bd),
        .i_status   (r_status),
        .o_wr_sel   (w_wr_sel),
        .o_addr     (Exception_RF_addr),
        .o_data     (Exceptiondata)
    );

    assign w_redirect = (r_state == ST_REDIRECT);

    assign busy                     = (r_state != ST_IDLE);
    assign Exception_Stall          = (r_state != ST_IDLE);
    assign Exception_clean          = w_redirect;
    assign Exception_Write_addr_sel = w_wr_sel;
    assign Exception_Write_data_sel = w_wr_sel;
    assign pc_redirect_valid        = w_redirect;
    assign pc_redirect_target       = w_redirect ? (r_eret ? r_epc : EXC_VECTOR) : 32'h0;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: steps through each sequence
// cycle by cycle and compares all outputs against hand-computed values.
module tb_exception_sequencer;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic        exc_in_delay_slot;
    logic        eret_valid;
    logic [31:0] cp0_status;
    logic [31:0] cp0_epc;
    logic        busy;
    logic        Exception_Stall;
    logic        Exception_clean;
    logic        Exception_Write_addr_sel;
    logic        Exception_Write_data_sel;
    logic [6:0]  Exception_RF_addr;
    logic [31:0] Exceptiondata;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect_target;

    int checks   = 0;
    int failures = 0;

    exception_sequencer dut (
        .clk                      (clk),
        .rst                      (rst),
        .exc_valid                (exc_valid),
        .exc_code                 (exc_code),
        .exc_pc                   (exc_pc),
        .exc_badvaddr             (exc_badvaddr),
        .exc_in_delay_slot        (exc_in_delay_slot),
        .eret_valid               (eret_valid),
        .cp0_status               (cp0_status),
        .cp0_epc                  (cp0_epc),
        .busy                     (busy),
        .Exception_Stall          (Exception_Stall),
        .Exception_clean          (Exception_clean),
        .Exception_Write_addr_sel (Exception_Write_addr_sel),
        .Exception_Write_data_sel (Exception_Write_data_sel),
        .Exception_RF_addr        (Exception_RF_addr),
        .Exceptiondata            (Exceptiondata),
        .pc_redirect_valid        (pc_redirect_valid),
        .pc_redirect_target       (pc_redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output for the current cycle.
    task automatic expect_cycle(input string tag, input logic stall, input logic clean,
                                input logic wsel, input logic [6:0] addr,
                                input logic [31:0] data, input logic rv,
                                input logic [31:0] tgt);
        chk({tag, ".busy"},   {31'b0, busy},                     {31'b0, stall});
        chk({tag, ".stall"},  {31'b0, Exception_Stall},          {31'b0, stall});
        chk({tag, ".clean"},  {31'b0, Exception_clean},          {31'b0, clean});
        chk({tag, ".asel"},   {31'b0, Exception_Write_addr_sel}, {31'b0, wsel});
        chk({tag, ".dsel"},   {31'b0, Exception_Write_data_sel}, {31'b0, wsel});
        chk({tag, ".addr"},   {25'b0, Exception_RF_addr},        {25'b0, addr});
        chk({tag, ".data"},   Exceptiondata,                     data);
        chk({tag, ".rvalid"}, {31'b0, pc_redirect_valid},        {31'b0, rv});
        chk({tag, ".target"}, pc_redirect_target,                tgt);
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid         = 1'b0;
        exc_code          = 5'h0;
        exc_pc            = 32'h0;
        exc_badvaddr      = 32'h0;
        exc_in_delay_slot = 1'b0;
        eret_valid        = 1'b0;
        cp0_status        = 32'h0;
        cp0_epc           = 32'h0;
    endtask

    task automatic expect_idle(input string tag);
        expect_cycle(tag, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        expect_idle("reset");
        rst = 1'b1;
        step();
        expect_idle("idle_after_reset");

        // Overflow, not in delay slot, EXL clear
        exc_valid = 1'b1; exc_code = 5'h0C; exc_pc = 32'hBFC00100; cp0_status = 32'h0;
        step();
        clear_inputs();
        expect_cycle("ov.c1", 1, 0, 1, 7'h38, 32'hBFC00100, 0, 32'h0);
        step();
        expect_cycle("ov.c2", 1, 0, 1, 7'h34, 32'h00000030, 0, 32'h0);
        step();
        expect_cycle("ov.c3", 1, 0, 1, 7'h30, 32'h00000002, 0, 32'h0);
        step();
        expect_cycle("ov.c4", 1, 1, 0, 7'h00, 32'h0, 1, 32'hBFC00380);
        step();
        expect_idle("ov.c5");

        // AdEL in delay slot
        exc_valid = 1'b1; exc_code = 5'h04; exc_pc = 32'h80001004;
        exc_in_delay_slot = 1'b1; exc_badvaddr = 32'h00000003; cp0_status = 32'h0;
        step();
        clear_inputs();
        expect_cycle("adel.c1", 1, 0, 1, 7'h38, 32'h80001000, 0, 32'h0);
        step();
        expect_cycle("adel.c2", 1, 0, 1, 7'h34, 32'h80000010, 0, 32'h0);
        step();
        expect_cycle("adel.c3", 1, 0, 1, 7'h30, 32'h00000002, 0, 32'h0);
        step();
        expect_cycle("adel.c4", 1, 0, 1, 7'h20, 32'h00000003, 0, 32'h0);
        step();
        expect_cycle("adel.c5", 1, 1, 0, 7'h00, 32'h0, 1, 32'hBFC00380);
        step();
        expect_idle("adel.c6");

        // ERET
        eret_valid = 1'b1; cp0_epc = 32'h80002000; cp0_status = 32'h3;
        step();
        clear_inputs();
        expect_cycle("eret.c1", 1, 0, 1, 7'h30, 32'h00000001, 0, 32'h0);
        step();
        expect_cycle("eret.c2", 1, 1, 0, 7'h00, 32'h0, 1, 32'h80002000);
        step();
        expect_idle("eret.c3");

        // Simultaneous exception and ERET; extra request during W_CAUSE
        exc_valid = 1'b1; eret_valid = 1'b1; exc_code = 5'h08; exc_pc = 32'h80000200;
        cp0_status = 32'h10; cp0_epc = 32'h80009999;
        step();
        clear_inputs();
        expect_cycle("both.c1", 1, 0, 1, 7'h38, 32'h80000200, 0, 32'h0);
        step();
        exc_valid = 1'b1; exc_code = 5'h0A; exc_pc = 32'h80000444; cp0_status = 32'h0;
        expect_cycle("both.c2", 1, 0, 1, 7'h34, 32'h00000020, 0, 32'h0);
        step();
        expect_cycle("both.c3", 1, 0, 1, 7'h30, 32'h00000012, 0, 32'h0);
        clear_inputs();
        step();
        expect_cycle("both.c4", 1, 1, 0, 7'h00, 32'h0, 1, 32'hBFC00380);
        step();
        expect_idle("both.c5");

        // Nested exception (EXL set): no EPC write
        exc_valid = 1'b1; exc_code = 5'h09; exc_pc = 32'h80000300; cp0_status = 32'h3;
        step();
        clear_inputs();
        expect_cycle("nest.c1", 1, 0, 1, 7'h34, 32'h00000024, 0, 32'h0);
        step();
        expect_cycle("nest.c2", 1, 0, 1, 7'h30, 32'h00000003, 0, 32'h0);
        step();
        expect_cycle("nest.c3", 1, 1, 0, 7'h00, 32'h0, 1, 32'hBFC00380);
        // Request presented during REDIRECT is taken in the first IDLE cycle
        exc_valid = 1'b1; exc_code = 5'h0C; exc_pc = 32'h80000400; cp0_status = 32'h0;
        step();
        expect_idle("b2b.idle");
        step();
        clear_inputs();
        expect_cycle("b2b.c1", 1, 0, 1, 7'h38, 32'h80000400, 0, 32'h0);
        step();
        expect_cycle("b2b.c2", 1, 0, 1, 7'h34, 32'h00000030, 0, 32'h0);
        step();
        expect_cycle("b2b.c3", 1, 0, 1, 7'h30, 32'h00000002, 0, 32'h0);

        // Reset during W_STATUS aborts the sequence
        rst = 1'b0;
        step();
        expect_idle("rst_mid.c1");
        rst = 1'b1;
        step();
        expect_idle("rst_mid.c2");
        step();
        expect_idle("rst_mid.c3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
